// File: rtl/store_buffer_if.sv
// rtl/store_buffer_if.sv - memory write port between the store buffer and the memory side
interface store_buffer_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready;

    modport master (
        output mem_req,
        output mem_addr,
        output mem_wdata,
        output mem_be,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        input  mem_wdata,
        input  mem_be,
        output mem_ready
    );
endinterface

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - in-order store buffer with commit tagging, flush and a drain FSM
module store_buffer #(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic [69:0]            store_in,
    input  logic [2:0]             store_width,
    input  logic                   commit_en,
    input  logic [5:0]             commit_tag,
    input  logic                   flush,
    store_buffer_if.master         mem,
    output logic                   full,
    output logic                   empty,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

    // Control bits live in vectors so reset can clear them; payload needs no reset.
    logic [DEPTH-1:0] ent_valid;
    logic [DEPTH-1:0] ent_committed;
    logic [5:0]       ent_tag   [DEPTH];
    logic [31:0]      ent_addr  [DEPTH];
    logic [31:0]      ent_data  [DEPTH];
    logic [1:0]       ent_width [DEPTH];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    state_t        state;

    logic          width_ok;
    logic          push;
    logic          pop;
    logic          commit_hit;
    logic [PW-1:0] commit_idx;
    logic [PW-1:0] scan_idx;
    logic [DEPTH-1:0] cmt_next;
    logic [CW-1:0] committed_cnt;
    logic [CW-1:0] count_next;

    logic [31:0]   head_addr;
    logic [31:0]   head_data;
    logic [3:0]    lane_be;
    logic [31:0]   lane_wdata;

    // Encodings 011..111 are not real store sizes and are silently discarded.
    assign width_ok = (store_width == 3'b000) || (store_width == 3'b001) || (store_width == 3'b010);
    // A full buffer rejects a new store even when the head drains in the same cycle.
    assign push     = en && !flush && !full && width_ok;
    assign pop      = (state == REQ) && mem.mem_ready;

    // Search from head for the oldest valid uncommitted entry carrying the retiring tag.
    always_comb begin
        commit_hit = 1'b0;
        commit_idx = '0;
        scan_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = head + PW'(i);
            if (commit_en && !commit_hit && ent_valid[scan_idx] &&
                !ent_committed[scan_idx] && (ent_tag[scan_idx] == commit_tag)) begin
                commit_hit = 1'b1;
                commit_idx = scan_idx;
            end
        end
    end

    // Committed set including this cycle's commit, so a same-cycle flush keeps it.
    always_comb begin
        cmt_next      = ent_committed;
        committed_cnt = '0;
        if (commit_hit) begin
            cmt_next[commit_idx] = 1'b1;
        end
        for (int i = 0; i < DEPTH; i++) begin
            committed_cnt = committed_cnt + CW'(ent_valid[i] & cmt_next[i]);
        end
    end

    // Occupancy after this edge; flush collapses it to the committed prefix.
    always_comb begin
        if (flush) begin
            count_next = committed_cnt - CW'(pop);
        end else begin
            count_next = count + CW'(push) - CW'(pop);
        end
    end

    // Byte-lane placement for the entry at head.
    always_comb begin
        head_addr = ent_addr[head];
        head_data = ent_data[head];
        case (ent_width[head])
            2'b00: begin
                lane_be    = 4'b0001 << head_addr[1:0];
                lane_wdata = {4{head_data[7:0]}};
            end
            2'b01: begin
                lane_be    = 4'b0011 << {head_addr[1], 1'b0};
                lane_wdata = {2{head_data[15:0]}};
            end
            default: begin
                lane_be    = 4'b1111;
                lane_wdata = head_data;
            end
        endcase
    end

    // Entry payload capture at tail.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_tag[tail]   <= store_in[69:64];
            ent_addr[tail]  <= store_in[63:32];
            ent_data[tail]  <= store_in[31:0];
            ent_width[tail] <= store_width[1:0];
        end
    end

    // Pointers, valid/committed bits, occupancy flags and sticky overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head          <= '0;
            tail          <= '0;
            ent_valid     <= '0;
            ent_committed <= '0;
            count         <= '0;
            full          <= 1'b0;
            empty         <= 1'b1;
            overflow      <= 1'b0;
        end else begin
            if (commit_hit) begin
                ent_committed[commit_idx] <= 1'b1;
            end
            if (pop) begin
                ent_valid[head]     <= 1'b0;
                ent_committed[head] <= 1'b0;
                head                <= head + 1'b1;
            end
            if (flush) begin
                // Committed entries form a contiguous run from head, so tail
                // lands right after them; the entry being drained is among them.
                for (int i = 0; i < DEPTH; i++) begin
                    if (!cmt_next[i]) begin
                        ent_valid[i] <= 1'b0;
                    end
                end
                tail <= head + committed_cnt[PW-1:0];
            end else if (push) begin
                ent_valid[tail]     <= 1'b1;
                ent_committed[tail] <= 1'b0;
                tail                <= tail + 1'b1;
            end
            if (en && !flush && full) begin
                overflow <= 1'b1;
            end
            count <= count_next;
            full  <= (count_next == CW'(DEPTH));
            empty <= (count_next == '0);
        end
    end

    // Drain FSM: launch a registered write for a committed head, hold it until accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            mem.mem_req   <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            mem.mem_be    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ent_valid[head] && ent_committed[head]) begin
                        state         <= REQ;
                        mem.mem_req   <= 1'b1;
                        mem.mem_addr  <= {head_addr[31:2], 2'b00};
                        mem.mem_wdata <= lane_wdata;
                        mem.mem_be    <= lane_be;
                    end
                end
                REQ: begin
                    if (mem.mem_ready) begin
                        state       <= IDLE;
                        mem.mem_req <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    mem.mem_req <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - directed self-checking bench for store_buffer
module tb_store_buffer;
    localparam int DEPTH = 8;

    logic        clk;
    logic        reset;
    logic        en;
    logic [69:0] store_in;
    logic [2:0]  store_width;
    logic        commit_en;
    logic [5:0]  commit_tag;
    logic        flush;
    logic        full;
    logic        empty;
    logic        overflow;
    logic [3:0]  count;

    int errors = 0;
    int checks = 0;

    store_buffer_if bus();

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .store_in    (store_in),
        .store_width (store_width),
        .commit_en   (commit_en),
        .commit_tag  (commit_tag),
        .flush       (flush),
        .mem         (bus),
        .full        (full),
        .empty       (empty),
        .overflow    (overflow),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        en            = 1'b0;
        store_in      = '0;
        store_width   = 3'b000;
        commit_en     = 1'b0;
        commit_tag    = '0;
        flush         = 1'b0;
        bus.mem_ready = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic push(input logic [5:0] t, input logic [31:0] a, input logic [31:0] d, input logic [2:0] w);
        en          = 1'b1;
        store_in    = {t, a, d};
        store_width = w;
        step();
        en = 1'b0;
    endtask

    task automatic commit(input logic [5:0] t);
        commit_en  = 1'b1;
        commit_tag = t;
        step();
        commit_en = 1'b0;
    endtask

    // Waits (bounded) for a request, captures it, then accepts it for one cycle.
    task automatic drain_one(output bit got, output logic [31:0] a, output logic [31:0] d, output logic [3:0] b);
        int n = 0;
        while (bus.mem_req !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        got = (bus.mem_req === 1'b1);
        a   = bus.mem_addr;
        d   = bus.mem_wdata;
        b   = bus.mem_be;
        if (got) begin
            bus.mem_ready = 1'b1;
            step();
            bus.mem_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b expected 0", bus.mem_req); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", empty); end
        checks++; if (full !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL reset_full_ovf: got %b%b expected 00", full, overflow); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        checks++; if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0 || bus.mem_be !== 4'h0) begin errors++; $display("FAIL reset_bus: got %h %h %b expected zeros", bus.mem_addr, bus.mem_wdata, bus.mem_be); end
    endtask

    task automatic test_sb_drain();
        bit got; logic [31:0] a; logic [31:0] d; logic [3:0] b;
        do_reset();
        push(6'd5, 32'h0000_1003, 32'h0000_00AB, 3'b000);
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL sb_count: got %0d expected 1", count); end
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL sb_no_req_uncommitted: got %b expected 0", bus.mem_req); end
        commit(6'd5);
        drain_one(got, a, d, b);
        checks++; if (!got) begin errors++; $display("FAIL sb_req_timeout: got no mem_req expected mem_req=1"); end
        checks++; if (a !== 32'h0000_1000) begin errors++; $display("FAIL sb_addr: got %h expected 00001000", a); end
        checks++; if (b !== 4'b1000) begin errors++; $display("FAIL sb_be: got %b expected 1000", b); end
        checks++; if (d !== 32'hABAB_ABAB) begin errors++; $display("FAIL sb_wdata: got %h expected abababab", d); end
        checks++; if (empty !== 1'b1 || bus.mem_req !== 1'b0) begin errors++; $display("FAIL sb_after_pop: got empty=%b req=%b expected 1 0", empty, bus.mem_req); end
    endtask

    task automatic test_lanes();
        bit got; logic [31:0] a; logic [31:0] d; logic [3:0] b;
        logic [31:0] exp_a [3] = '{32'h0000_5000, 32'h0000_6000, 32'h0000_4000};
        logic [31:0] exp_d [3] = '{32'h5A5A_5A5A, 32'h9876_9876, 32'hDEAD_BEEF};
        logic [3:0]  exp_b [3] = '{4'b0010, 4'b0011, 4'b1111};
        int seen = 0;
        do_reset();
        push(6'd20, 32'h0000_5001, 32'h0000_005A, 3'b000);
        push(6'd21, 32'h0000_6001, 32'h0000_9876, 3'b001);
        push(6'd22, 32'h0000_4003, 32'hDEAD_BEEF, 3'b010);
        push(6'd23, 32'h0000_7000, 32'h0000_1111, 3'b011);
        checks++; if (count !== 4'd3) begin errors++; $display("FAIL bad_width_count: got %0d expected 3", count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL bad_width_ovf: got %b expected 0", overflow); end
        commit(6'd20);
        commit(6'd21);
        commit(6'd22);
        commit(6'd23);
        for (int i = 0; i < 3; i++) begin
            drain_one(got, a, d, b);
            checks++;
            if (!got || a !== exp_a[i] || d !== exp_d[i] || b !== exp_b[i]) begin
                errors++;
                $display("FAIL lane_%0d: got req=%b %h %h %b expected 1 %h %h %b", i, got, a, d, b, exp_a[i], exp_d[i], exp_b[i]);
            end
        end
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.mem_req === 1'b1) seen++;
        end
        checks++; if (seen != 0 || empty !== 1'b1) begin errors++; $display("FAIL lane_extra: got %0d extra req cycles empty=%b expected 0 1", seen, empty); end
    endtask

    task automatic test_full_overflow();
        bit got; logic [31:0] a; logic [31:0] d; logic [3:0] b;
        int n = 0;
        logic [5:0]  tags  [8] = '{6'd12, 6'd13, 6'd14, 6'd15, 6'd16, 6'd17, 6'd40, 6'd41};
        logic [31:0] exp_a [8] = '{32'h108, 32'h10C, 32'h110, 32'h114, 32'h118, 32'h11C, 32'h200, 32'h204};
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            push(6'(10 + i), 32'h100 + 32'(4 * i), 32'(i), 3'b010);
        end
        checks++; if (count !== 4'd8 || full !== 1'b1 || overflow !== 1'b0) begin errors++; $display("FAIL fill: got count=%0d full=%b ovf=%b expected 8 1 0", count, full, overflow); end
        push(6'd30, 32'h0000_0300, 32'h0, 3'b010);
        checks++; if (count !== 4'd8 || full !== 1'b1 || overflow !== 1'b1) begin errors++; $display("FAIL overflow: got count=%0d full=%b ovf=%b expected 8 1 1", count, full, overflow); end
        commit(6'd10);
        while (bus.mem_req !== 1'b1 && n < 20) begin step(); n++; end
        checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h100) begin errors++; $display("FAIL full_first_req: got req=%b addr=%h expected 1 00000100", bus.mem_req, bus.mem_addr); end
        // Pop and push in one cycle while full: the push must be rejected.
        bus.mem_ready = 1'b1;
        en            = 1'b1;
        store_in      = {6'd31, 32'h0000_0900, 32'h0};
        store_width   = 3'b010;
        step();
        bus.mem_ready = 1'b0;
        en            = 1'b0;
        checks++; if (count !== 4'd7 || full !== 1'b0) begin errors++; $display("FAIL full_pop_push: got count=%0d full=%b expected 7 0", count, full); end
        commit(6'd11);
        drain_one(got, a, d, b);
        checks++; if (!got || a !== 32'h104 || count !== 4'd6) begin errors++; $display("FAIL second_drain: got req=%b addr=%h count=%0d expected 1 00000104 6", got, a, count); end
        push(6'd40, 32'h0000_0200, 32'h40, 3'b010);
        push(6'd41, 32'h0000_0204, 32'h41, 3'b010);
        checks++; if (count !== 4'd8 || full !== 1'b1) begin errors++; $display("FAIL refill_wrap: got count=%0d full=%b expected 8 1", count, full); end
        for (int i = 0; i < 8; i++) commit(tags[i]);
        for (int i = 0; i < 8; i++) begin
            drain_one(got, a, d, b);
            checks++;
            if (!got || a !== exp_a[i]) begin
                errors++;
                $display("FAIL wrap_order_%0d: got req=%b addr=%h expected 1 %h", i, got, a, exp_a[i]);
            end
        end
        checks++; if (empty !== 1'b1 || overflow !== 1'b1) begin errors++; $display("FAIL wrap_end: got empty=%b ovf=%b expected 1 1", empty, overflow); end
    endtask

    task automatic test_flush();
        bit got; logic [31:0] a; logic [31:0] d; logic [3:0] b;
        int seen = 0;
        do_reset();
        push(6'd1, 32'h0000_0300, 32'h1, 3'b010);
        push(6'd2, 32'h0000_0304, 32'h2, 3'b010);
        push(6'd3, 32'h0000_0308, 32'h3, 3'b010);
        commit(6'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL flush_count: got %0d expected 1", count); end
        drain_one(got, a, d, b);
        checks++; if (!got || a !== 32'h300) begin errors++; $display("FAIL flush_drain: got req=%b addr=%h expected 1 00000300", got, a); end
        commit(6'd2);
        commit(6'd3);
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.mem_req === 1'b1) seen++;
        end
        checks++; if (seen != 0 || empty !== 1'b1) begin errors++; $display("FAIL flush_discard: got %0d req cycles empty=%b expected 0 1", seen, empty); end
        push(6'd4, 32'h0000_030C, 32'h4, 3'b010);
        commit(6'd4);
        drain_one(got, a, d, b);
        checks++; if (!got || a !== 32'h30C || empty !== 1'b1) begin errors++; $display("FAIL flush_tail: got req=%b addr=%h empty=%b expected 1 0000030c 1", got, a, empty); end
    endtask

    task automatic test_stall();
        bit got; logic [31:0] a; logic [31:0] d; logic [3:0] b;
        int n = 0;
        do_reset();
        push(6'd7, 32'h0000_2002, 32'h0000_1234, 3'b001);
        commit(6'd7);
        while (bus.mem_req !== 1'b1 && n < 20) begin step(); n++; end
        checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h2000 || bus.mem_be !== 4'b1100 || bus.mem_wdata !== 32'h1234_1234) begin
            errors++; $display("FAIL sh_req: got req=%b %h %b %h expected 1 00002000 1100 12341234", bus.mem_req, bus.mem_addr, bus.mem_be, bus.mem_wdata);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h2000 || bus.mem_be !== 4'b1100 || bus.mem_wdata !== 32'h1234_1234 || count !== 4'd1) begin
                errors++; $display("FAIL stall_%0d: got req=%b %h %b %h count=%0d expected 1 00002000 1100 12341234 1", i, bus.mem_req, bus.mem_addr, bus.mem_be, bus.mem_wdata, count);
            end
        end
        bus.mem_ready = 1'b1;
        en            = 1'b1;
        store_in      = {6'd9, 32'h0000_2100, 32'h0000_0077};
        store_width   = 3'b010;
        step();
        bus.mem_ready = 1'b0;
        en            = 1'b0;
        checks++; if (bus.mem_req !== 1'b0 || count !== 4'd1) begin errors++; $display("FAIL pop_push: got req=%b count=%0d expected 0 1", bus.mem_req, count); end
        commit(6'd9);
        drain_one(got, a, d, b);
        checks++; if (!got || a !== 32'h2100 || d !== 32'h77 || b !== 4'b1111) begin errors++; $display("FAIL pushed_during_pop: got req=%b %h %h %b expected 1 00002100 00000077 1111", got, a, d, b); end
    endtask

    task automatic test_commit_flush_same();
        bit got; logic [31:0] a; logic [31:0] d; logic [3:0] b;
        int seen = 0;
        do_reset();
        push(6'd1, 32'h0000_0700, 32'h1, 3'b010);
        push(6'd2, 32'h0000_0704, 32'h2, 3'b010);
        push(6'd3, 32'h0000_0708, 32'h3, 3'b010);
        commit(6'd1);
        commit_en  = 1'b1;
        commit_tag = 6'd2;
        flush      = 1'b1;
        en         = 1'b1;
        store_in   = {6'd9, 32'h0000_0900, 32'h0};
        step();
        commit_en = 1'b0;
        flush     = 1'b0;
        en        = 1'b0;
        checks++; if (count !== 4'd2 || overflow !== 1'b0) begin errors++; $display("FAIL cf_count: got count=%0d ovf=%b expected 2 0", count, overflow); end
        drain_one(got, a, d, b);
        checks++; if (!got || a !== 32'h700) begin errors++; $display("FAIL cf_first: got req=%b addr=%h expected 1 00000700", got, a); end
        drain_one(got, a, d, b);
        checks++; if (!got || a !== 32'h704) begin errors++; $display("FAIL cf_second: got req=%b addr=%h expected 1 00000704", got, a); end
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.mem_req === 1'b1) seen++;
        end
        checks++; if (seen != 0 || empty !== 1'b1) begin errors++; $display("FAIL cf_end: got %0d req cycles empty=%b expected 0 1", seen, empty); end
    endtask

    task automatic test_reset_mid_req();
        int n = 0;
        int seen = 0;
        do_reset();
        push(6'd1, 32'h0000_0A00, 32'h1, 3'b010);
        push(6'd2, 32'h0000_0A04, 32'h2, 3'b010);
        commit(6'd1);
        while (bus.mem_req !== 1'b1 && n < 20) begin step(); n++; end
        checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL mid_req_start: got %b expected 1", bus.mem_req); end
        reset = 1'b1;
        #1;
        checks++; if (bus.mem_req !== 1'b0 || count !== 4'd0 || empty !== 1'b1 || bus.mem_be !== 4'h0) begin
            errors++; $display("FAIL async_reset: got req=%b count=%0d empty=%b be=%b expected 0 0 1 0000", bus.mem_req, count, empty, bus.mem_be);
        end
        step();
        reset = 1'b0;
        step();
        commit(6'd1);
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.mem_req === 1'b1) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL reset_lost: got %0d req cycles expected 0", seen); end
    endtask

    initial begin
        test_reset();
        test_sb_drain();
        test_lanes();
        test_full_overflow();
        test_flush();
        test_stall();
        test_commit_flush_same();
        test_reset_mid_req();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
